pc_next_ctrl: RTL and testbench
===============================

Name: pc_next_ctrl

Overview:
Initiator side of the program-counter write interface. It sequences instructions with a 4-phase multi-cycle FSM and computes the next address. It drives PCNext/PCWrite into the ProgramCounter and reads the committed PCResult back. It resolves increment, conditional branch and jump, and supports stall and halt.

Parameters:
PC_WIDTH, 5, width of PCNext/PCResult/targets
RESET_PC, 0, PCNext value driven out of reset

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset (0 = reset)
Start  input  1  level; leaves IDLE when high
Stop  input  1  level; return to IDLE after current UPDATE
Stall  input  1  freezes FSM in current state
PCResult  input  PC_WIDTH  committed PC from ProgramCounter
JumpReq  input  1  unconditional jump request, sampled in DECODE
JumpTarget  input  PC_WIDTH  absolute target, sampled in DECODE
BranchReq  input  1  conditional branch request, sampled in DECODE
BranchTaken  input  1  branch condition, sampled in DECODE
BranchOffset  input  PC_WIDTH  two's-complement offset, sampled in DECODE
PCNext  output  PC_WIDTH  registered next address
PCWrite  output  1  registered write strobe, high exactly in UPDATE
Busy  output  1  high in FETCH/DECODE/EXEC/UPDATE
Halted  output  1  high in HALT
State  output  3  encoded FSM state for debug

Behaviour:
- Reset low, asynchronous, at any time including mid-instruction:
  - State=IDLE, PCNext=RESET_PC, PCWrite=0, Busy=0, Halted=0.
  - Latched request registers are cleared.
- States: IDLE(0), FETCH(1), DECODE(2), EXEC(3), UPDATE(4), HALT(5).
- IDLE: goes to FETCH on the edge where Start=1. Otherwise stays.
- Sequence: FETCH -> DECODE -> EXEC -> UPDATE, one cycle each when Stall=0. One instruction takes 4 cycles.
- DECODE edge latches JumpReq, JumpTarget, BranchReq&BranchTaken and BranchOffset. Inputs outside DECODE are ignored.
- EXEC edge computes the target from PCResult and registers it into PCNext. PCWrite is set to 1 on the same edge. Target priority:
  1. Jump: JumpTarget.
  2. Taken branch: PCResult + 1 + BranchOffset.
  3. Otherwise: PCResult + 1.
- Arithmetic is modulo 2^PC_WIDTH with wrap-around: 31+1=0, and 2+1+(-4) gives 31.
- UPDATE: PCWrite=1 for exactly one non-stalled cycle, and the PC commits at the end of it. PCWrite is cleared on the UPDATE exit edge. PCNext holds its value until the next EXEC edge.
- UPDATE exit, in priority order:
  1. If the latched jump target equals the PCResult sampled in EXEC (self-jump), go to HALT.
  2. Else if Stop=1, go to IDLE.
  3. Else go to FETCH.
- HALT: Halted=1, PCWrite=0, Busy=0. Only Reset exits; Start is ignored.
- Stall=1 in any non-IDLE/HALT state holds State, PCNext and the latched registers.
  - In UPDATE, Stall forces PCWrite low for that cycle. The write is retried on the next non-stalled cycle, still exactly one strobe per instruction.
- Simultaneous events:
  - JumpReq and taken branch together: jump wins.
  - BranchReq=1 with BranchTaken=0: increment.
  - Stop and Stall together in UPDATE: Stall wins, and Stop is re-sampled at exit.
- PCWrite is never high outside UPDATE.

Decomposition:
- Package pc_ctrl_pkg:
  - PC_WIDTH default constant.
  - State enum with the encodings above.
  - Target-select enum (INC/BRANCH/JUMP).
- Sub-module pc_target_calc: combinational. Inputs are PCResult, the latched requests and the offset. Outputs are the target and a self-jump flag. It is unit-testable in isolation.

Test Plan:
1. Reset low mid-DECODE with PCNext=7 -> PCNext=0, PCWrite=0, State=IDLE immediately, without waiting for a clock edge.
2. Start=1, no requests, PCResult=4 -> PCWrite high only in cycle 4 after Start, PCNext=5. With PC fed back, next instruction PCNext=6.
3. DECODE with BranchReq=1, BranchTaken=1, BranchOffset=5'b11100 (-4), PCResult=2 -> PCNext=31 (wrap). With BranchTaken=0 -> PCNext=3.
4. JumpReq=1, JumpTarget=12, together with taken branch, PCResult=4 -> PCNext=12 (jump wins). PCResult=31 with increment -> PCNext=0.
5. Stall=1 for 3 cycles during UPDATE -> PCWrite low while stalled, then exactly one PCWrite pulse with unchanged PCNext. Stop=1 at UPDATE exit -> IDLE, Busy=0.
6. JumpTarget=30 while PCResult=30 -> one PCWrite with PCNext=30, then HALT, Halted=1. Start ignored; only Reset returns to IDLE.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared types for the program-counter next-address controller:
// FSM state encoding, target-select encoding and the target priority rule.
package pc_ctrl_pkg;

   localparam int PC_WIDTH_DEFAULT = 5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_UPDATE = 3'd4,
      ST_HALT   = 3'd5
   } pc_state_e;

   typedef enum logic [1:0] {
      SEL_INC    = 2'd0,
      SEL_BRANCH = 2'd1,
      SEL_JUMP   = 2'd2
   } tgt_sel_e;

   // Jump outranks a taken branch; anything else is a plain increment.
   function automatic tgt_sel_e select_target(input logic jump, input logic branch_taken);
      if (jump) begin
         return SEL_JUMP;
      end else if (branch_taken) begin
         return SEL_BRANCH;
      end
      return SEL_INC;
   endfunction

endpackage

// File: rtl/pc_next_ctrl_if.sv
// Bundle between the next-address controller (master) and the ProgramCounter
// plus instruction-side request sources (slave).
interface pc_next_ctrl_if #(
   parameter int PC_WIDTH = pc_ctrl_pkg::PC_WIDTH_DEFAULT
);
   // PCWrite is a one-cycle write strobe with no back-pressure: the ProgramCounter
   // commits PCNext on every rising edge that ends a cycle with PCWrite=1, and
   // PCResult is expected to reflect that commit from the next cycle onward.
   logic                Start;
   logic                Stop;
   logic                Stall;
   logic [PC_WIDTH-1:0] PCResult;
   logic                JumpReq;
   logic [PC_WIDTH-1:0] JumpTarget;
   logic                BranchReq;
   logic                BranchTaken;
   logic [PC_WIDTH-1:0] BranchOffset;
   logic [PC_WIDTH-1:0] PCNext;
   logic                PCWrite;
   logic                Busy;
   logic                Halted;
   logic [2:0]          State;

   modport master (
      input  Start, Stop, Stall, PCResult,
      input  JumpReq, JumpTarget, BranchReq, BranchTaken, BranchOffset,
      output PCNext, PCWrite, Busy, Halted, State
   );

   modport slave (
      output Start, Stop, Stall, PCResult,
      output JumpReq, JumpTarget, BranchReq, BranchTaken, BranchOffset,
      input  PCNext, PCWrite, Busy, Halted, State
   );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-address calculation from the committed PC and the
// requests latched in DECODE; also flags a jump onto the current PC.
module pc_target_calc
   import pc_ctrl_pkg::*;
#(
   parameter int PC_WIDTH = PC_WIDTH_DEFAULT
) (
   input  logic [PC_WIDTH-1:0] pc_result_i,
   input  logic                jump_i,
   input  logic [PC_WIDTH-1:0] jump_target_i,
   input  logic                branch_taken_i,
   input  logic [PC_WIDTH-1:0] branch_offset_i,
   output logic [PC_WIDTH-1:0] target_o,
   output logic                self_jump_o
);

   tgt_sel_e            sel;
   logic [PC_WIDTH-1:0] pc_inc;

   // Sums are PC_WIDTH wide so they wrap modulo 2^PC_WIDTH by construction.
   assign pc_inc = pc_result_i + PC_WIDTH'(1);

   always_comb begin
      sel      = select_target(jump_i, branch_taken_i);
      target_o = pc_inc;
      unique case (sel)
         SEL_JUMP:   target_o = jump_target_i;
         SEL_BRANCH: target_o = pc_inc + branch_offset_i;
         default:    target_o = pc_inc;
      endcase
   end

   assign self_jump_o = jump_i && (jump_target_i == pc_result_i);

endmodule

// File: rtl/pc_next_ctrl.sv
// Four-phase instruction sequencer that computes and writes the next PC,
// with stall, stop-to-idle and halt-on-self-jump.
module pc_next_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter int                  PC_WIDTH = PC_WIDTH_DEFAULT,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic          Clk,
   input  logic          Reset,
   pc_next_ctrl_if.master bus
);

   pc_state_e           state_q, state_d;
   logic [PC_WIDTH-1:0] pc_next_q, pc_next_d;
   logic                pc_write_q, pc_write_d;
   logic                jump_q, jump_d;
   logic [PC_WIDTH-1:0] jump_tgt_q, jump_tgt_d;
   logic                br_taken_q, br_taken_d;
   logic [PC_WIDTH-1:0] br_off_q, br_off_d;
   logic                self_jump_q, self_jump_d;

   logic [PC_WIDTH-1:0] target;
   logic                self_jump;
   logic                advance;

   assign advance = !bus.Stall;

   pc_target_calc #(
      .PC_WIDTH (PC_WIDTH)
   ) u_target_calc (
      .pc_result_i     (bus.PCResult),
      .jump_i          (jump_q),
      .jump_target_i   (jump_tgt_q),
      .branch_taken_i  (br_taken_q),
      .branch_offset_i (br_off_q),
      .target_o        (target),
      .self_jump_o     (self_jump)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (bus.Start) state_d = ST_FETCH;
         ST_FETCH:  if (advance) state_d = ST_DECODE;
         ST_DECODE: if (advance) state_d = ST_EXEC;
         ST_EXEC:   if (advance) state_d = ST_UPDATE;
         ST_UPDATE: begin
            // Exit decisions wait for a non-stalled cycle, so Stop is re-sampled then.
            if (advance) begin
               if (self_jump_q) begin
                  state_d = ST_HALT;
               end else if (bus.Stop) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.State  = state_q;
      bus.PCNext = pc_next_q;
      bus.Busy   = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                   (state_q == ST_EXEC)  || (state_q == ST_UPDATE);
      bus.Halted = (state_q == ST_HALT);
      // A stalled UPDATE cycle must not commit; the strobe reappears once Stall drops.
      bus.PCWrite = pc_write_q && (state_q == ST_UPDATE) && !bus.Stall;
   end

   always_comb begin
      pc_next_d   = pc_next_q;
      pc_write_d  = pc_write_q;
      jump_d      = jump_q;
      jump_tgt_d  = jump_tgt_q;
      br_taken_d  = br_taken_q;
      br_off_d    = br_off_q;
      self_jump_d = self_jump_q;
      unique case (state_q)
         ST_DECODE: begin
            if (advance) begin
               jump_d     = bus.JumpReq;
               jump_tgt_d = bus.JumpTarget;
               br_taken_d = bus.BranchReq && bus.BranchTaken;
               br_off_d   = bus.BranchOffset;
            end
         end
         ST_EXEC: begin
            if (advance) begin
               pc_next_d   = target;
               self_jump_d = self_jump;
               pc_write_d  = 1'b1;
            end
         end
         ST_UPDATE: begin
            if (advance) pc_write_d = 1'b0;
         end
         default: begin
            pc_write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pc_next_q   <= RESET_PC;
         pc_write_q  <= 1'b0;
         jump_q      <= 1'b0;
         jump_tgt_q  <= '0;
         br_taken_q  <= 1'b0;
         br_off_q    <= '0;
         self_jump_q <= 1'b0;
      end else begin
         pc_next_q   <= pc_next_d;
         pc_write_q  <= pc_write_d;
         jump_q      <= jump_d;
         jump_tgt_q  <= jump_tgt_d;
         br_taken_q  <= br_taken_d;
         br_off_q    <= br_off_d;
         self_jump_q <= self_jump_d;
      end
   end

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Directed bench for pc_next_ctrl: a stimulus process pushes the expected PCNext
// of each instruction, and a negedge monitor checks every PCWrite strobe.
module tb_pc_next_ctrl;

   logic       Clk;
   logic       Reset;
   logic [4:0] pc_reg;

   int total = 0;
   int bad   = 0;

   logic [4:0] exp_q[$];

   pc_next_ctrl_if #(.PC_WIDTH(5)) bus ();

   pc_next_ctrl #(
      .PC_WIDTH (5),
      .RESET_PC (5'd0)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   assign bus.PCResult = pc_reg;

   // Clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ProgramCounter model: commits PCNext on a write strobe
   always @(posedge Clk) begin
      if (bus.PCWrite) pc_reg <= bus.PCNext;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge Clk) begin
      if (Reset && bus.PCWrite) begin
         chk("write in UPDATE", int'(bus.State), 4);
         if (exp_q.size() == 0) begin
            chk("unexpected write", 1, 0);
         end else begin
            chk("PCNext at write", int'(bus.PCNext), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_req(input logic jr, input logic [4:0] jt, input logic br,
                          input logic bt, input logic [4:0] bo);
      bus.JumpReq      = jr;
      bus.JumpTarget   = jt;
      bus.BranchReq    = br;
      bus.BranchTaken  = bt;
      bus.BranchOffset = bo;
   endtask

   // One instruction from IDLE with Stop held high; checks per-cycle state/strobe
   task automatic do_instr(input string name, input bit set_pc, input logic [4:0] pc,
                           input logic jr, input logic [4:0] jt, input logic br,
                           input logic bt, input logic [4:0] bo,
                           input logic [4:0] exp_pc, input int exit_st);
      if (set_pc) pc_reg = pc;
      set_req(jr, jt, br, bt, bo);
      bus.Stop  = 1'b1;
      bus.Start = 1'b1;
      exp_q.push_back(exp_pc);
      for (int k = 1; k <= 4; k++) begin
         step();
         bus.Start = 1'b0;
         chk({name, " state"}, int'(bus.State), k);
         chk({name, " PCWrite"}, int'(bus.PCWrite), int'(k == 4));
      end
      step();
      chk({name, " exit state"}, int'(bus.State), exit_st);
      chk({name, " PCWrite after"}, int'(bus.PCWrite), 0);
   endtask

   initial begin
      Reset     = 1'b0;
      pc_reg    = 5'd0;
      bus.Start = 1'b0;
      bus.Stop  = 1'b0;
      bus.Stall = 1'b0;
      set_req(1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
      #12;
      chk("reset State", int'(bus.State), 0);
      chk("reset PCNext", int'(bus.PCNext), 0);
      chk("reset PCWrite", int'(bus.PCWrite), 0);
      chk("reset Busy", int'(bus.Busy), 0);
      chk("reset Halted", int'(bus.Halted), 0);
      step();
      Reset = 1'b1;
      step();
      chk("idle without Start", int'(bus.State), 0);

      // increment, then increment from the fed-back PC
      do_instr("inc4", 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd5, 0);
      do_instr("inc fb", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd6, 0);

      // branches: taken with negative offset wraps, not-taken increments
      do_instr("br taken", 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 5'b11100, 5'd31, 0);
      do_instr("br not taken", 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 5'b11100, 5'd3, 0);

      // jump beats taken branch; increment wraps at the top
      do_instr("jump wins", 1'b1, 5'd4, 1'b1, 5'd12, 1'b1, 1'b1, 5'd3, 5'd12, 0);
      do_instr("inc wrap", 1'b1, 5'd31, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 0);
      chk("PC fed back", int'(pc_reg), 0);

      // 3-cycle stall in UPDATE with Stop held: single retried strobe, then IDLE
      pc_reg = 5'd6;
      set_req(1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
      bus.Stop  = 1'b1;
      bus.Start = 1'b1;
      exp_q.push_back(5'd7);
      for (int k = 1; k <= 4; k++) begin
         step();
         bus.Start = 1'b0;
      end
      bus.Stall = 1'b1;
      #1;
      chk("stall PCWrite low", int'(bus.PCWrite), 0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall state held", int'(bus.State), 4);
         chk("stall PCWrite held low", int'(bus.PCWrite), 0);
         chk("stall PCNext held", int'(bus.PCNext), 7);
      end
      bus.Stall = 1'b0;
      #1;
      chk("unstall PCWrite", int'(bus.PCWrite), 1);
      chk("unstall PCNext", int'(bus.PCNext), 7);
      step();
      chk("stop to IDLE", int'(bus.State), 0);
      chk("stop Busy", int'(bus.Busy), 0);
      chk("stop PCWrite", int'(bus.PCWrite), 0);

      // asynchronous reset in the middle of DECODE
      bus.Start = 1'b1;
      step();
      bus.Start = 1'b0;
      step();
      chk("pre-reset state", int'(bus.State), 2);
      chk("pre-reset PCNext", int'(bus.PCNext), 7);
      #2;
      Reset = 1'b0;
      #1;
      chk("async reset State", int'(bus.State), 0);
      chk("async reset PCNext", int'(bus.PCNext), 0);
      chk("async reset PCWrite", int'(bus.PCWrite), 0);
      chk("async reset Busy", int'(bus.Busy), 0);
      step();
      Reset = 1'b1;
      step();

      // self-jump: one write of 30, then HALT that ignores Start
      do_instr("self jump", 1'b1, 5'd30, 1'b1, 5'd30, 1'b0, 1'b0, 5'd0, 5'd30, 5);
      bus.Start = 1'b1;
      bus.Stop  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("halt state", int'(bus.State), 5);
         chk("halt Halted", int'(bus.Halted), 1);
         chk("halt Busy", int'(bus.Busy), 0);
         chk("halt PCWrite", int'(bus.PCWrite), 0);
      end
      bus.Start = 1'b0;
      #2;
      Reset = 1'b0;
      #1;
      chk("halt reset State", int'(bus.State), 0);
      chk("halt reset Halted", int'(bus.Halted), 0);
      step();
      Reset = 1'b1;
      step();
      chk("idle after halt reset", int'(bus.State), 0);

      chk("queue drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
